// File: rtl/node_interface_pkg.sv
// Shared mesh configuration: node count macros, node index width helper and the packet format.
`ifndef NODE_INTERFACE_PKG_SV
`define NODE_INTERFACE_PKG_SV

`define X_NODES 2
`define Y_NODES 2
`define NODES (`X_NODES * `Y_NODES)

package node_interface_pkg;

  localparam int DATA_W = 16;

  function automatic int node_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NODE_W = node_id_w(`NODES);

  typedef logic [NODE_W-1:0] node_idx_t;

  typedef struct packed {
    node_idx_t         dest;
    node_idx_t         source;
    logic [DATA_W-1:0] data;
  } packet_t;

endpackage

`endif

// File: rtl/node_interface_sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally, no bypass (push to head in 1 cycle).
// Push while full and pop while empty are ignored; the producer must hold its data until accepted.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/node_interface.sv
// Node network interface: injection FIFO (1-cycle push-to-valid), registered ejection (1 cycle).
// Injection holds head while i_net_en is low; ejection never backpressures, misrouted packets are dropped.
module node_interface
  import node_interface_pkg::*;
#(
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  packet_t          i_pkt,
  input  logic             i_pkt_val,
  output logic             o_pkt_rdy,
  output packet_t          o_net_data,
  output logic             o_net_data_val,
  input  logic             i_net_en,
  input  packet_t          i_net_data,
  input  logic             i_net_data_val,
  output packet_t          o_rx_data,
  output logic             o_rx_val,
  output logic             o_misroute,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int        AW   = $clog2(FIFO_DEPTH);
  localparam node_idx_t SELF = node_idx_t'(NODE_ID);

  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          pop;
  logic          rx_hit;
  logic          rx_miss;
  logic          stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign o_pkt_rdy      = ~full;
  assign o_net_data_val = (count != '0);
  assign pop            = ~empty & i_net_en;
  assign stall          = o_net_data_val & ~i_net_en;
  assign rx_hit         = i_net_data_val & (i_net_data.dest == SELF);
  assign rx_miss        = i_net_data_val & (i_net_data.dest != SELF);

  sync_fifo #(
    .T     (packet_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (i_pkt_val & o_pkt_rdy),
    .pop   (pop),
    .din   (i_pkt),
    .head  (o_net_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      o_rx_val      <= 1'b0;
      o_rx_data     <= '0;
      o_misroute    <= 1'b0;
      o_tx_count    <= '0;
      o_rx_count    <= '0;
      o_stall_count <= '0;
    end else begin
      o_rx_val <= rx_hit;
      if (rx_hit)  o_rx_data  <= i_net_data;
      if (rx_miss) o_misroute <= 1'b1;
      o_tx_count    <= sat_inc(o_tx_count, pop);
      o_rx_count    <= sat_inc(o_rx_count, rx_hit);
      o_stall_count <= sat_inc(o_stall_count, stall);
    end
  end

endmodule
